// File: rtl/ram_arb_pkg.sv
// Shared constants for the RAM port arbiter: requester IDs, default widths
// and the lock FSM encoding.
package ram_arb_pkg;
    localparam int REQ_CPU      = 0;
    localparam int REQ_DBG      = 1;
    localparam int NUM_REQ      = 2;
    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_LOCK = 8;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FORCED   = 2'd2
    } lock_state_e;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: request, grant and read
// response for the CPU (0) and debug (1) requesters.
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req0_valid, i_req1_valid;
    logic                  i_req0_we, i_req1_we;
    logic [ADDR_WIDTH-1:0] i_req0_addr, i_req1_addr;
    logic [DATA_WIDTH-1:0] i_req0_wdata, i_req1_wdata;
    logic                  i_req1_lock;
    logic                  o_req0_ready, o_req1_ready;
    logic                  o_req0_rvalid, o_req1_rvalid;
    logic [DATA_WIDTH-1:0] o_req0_rdata, o_req1_rdata;

    modport master (
        output i_req0_valid, i_req0_we, i_req0_addr, i_req0_wdata,
        output i_req1_valid, i_req1_we, i_req1_addr, i_req1_wdata, i_req1_lock,
        input  o_req0_ready, o_req1_ready, o_req0_rvalid, o_req1_rvalid,
        input  o_req0_rdata, o_req1_rdata
    );

    modport slave (
        input  i_req0_valid, i_req0_we, i_req0_addr, i_req0_wdata,
        input  i_req1_valid, i_req1_we, i_req1_addr, i_req1_wdata, i_req1_lock,
        output o_req0_ready, o_req1_ready, o_req0_rvalid, o_req1_rvalid,
        output o_req0_rdata, o_req1_rdata
    );
endinterface

// File: rtl/ram_arb_grant.sv
// Round-robin grant with a bounded debug lock. FORCED is the single cycle
// in which the CPU is served after the debug unit used up its lock budget.
module ram_arb_grant
    import ram_arb_pkg::*;
#(
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               lock,
    output logic [NUM_REQ-1:0] grant
);
    lock_state_e state, state_nxt;
    logic [7:0]  lock_cnt, cnt_nxt;
    logic [8:0]  cnt_inc;
    logic        last_grant, last_nxt;

    always_comb begin
        grant     = '0;
        state_nxt = UNLOCKED;
        cnt_nxt   = '0;
        last_nxt  = last_grant;
        cnt_inc   = {1'b0, lock_cnt} + 9'(valid[REQ_CPU]);
        unique case (state)
            LOCKED: grant[REQ_DBG] = valid[REQ_DBG];
            FORCED: begin
                grant[REQ_CPU] = valid[REQ_CPU];
                grant[REQ_DBG] = valid[REQ_DBG] & ~valid[REQ_CPU];
            end
            default: grant = (&valid) ? (last_grant ? 2'b01 : 2'b10) : valid;
        endcase
        if (!i_rst_n) grant = '0;
        if (|grant) last_nxt = grant[REQ_DBG];
        // Budget only counts cycles where the CPU is actually kept waiting.
        if (state != FORCED && grant[REQ_DBG] && lock) begin
            cnt_nxt   = cnt_inc[7:0];
            state_nxt = (cnt_inc == 9'(MAX_LOCK)) ? FORCED : LOCKED;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= UNLOCKED;
            lock_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            lock_cnt   <= cnt_nxt;
            last_grant <= last_nxt;
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one async-read single-port RAM between CPU and debug requesters;
// muxes the granted request onto the RAM and registers read responses.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_W,
    parameter int DATA_WIDTH = DEF_DATA_W,
    parameter int MAX_LOCK   = DEF_MAX_LOCK
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ram_port_arbiter_if.slave     bus,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata
);
    logic [NUM_REQ-1:0]                 valid, we, grant, rvalid_q;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata, rdata_q;

    assign valid = {bus.i_req1_valid, bus.i_req0_valid};
    assign we    = {bus.i_req1_we,    bus.i_req0_we};
    assign addr  = {bus.i_req1_addr,  bus.i_req0_addr};
    assign wdata = {bus.i_req1_wdata, bus.i_req0_wdata};

    ram_arb_grant #(.MAX_LOCK(MAX_LOCK)) u_grant (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .valid   (valid),
        .lock    (bus.i_req1_lock),
        .grant   (grant)
    );

    // Grant is one-hot or zero, so an OR-style scan is a clean mux.
    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                o_ram_we    = we[i];
                o_ram_addr  = addr[i];
                o_ram_wdata = wdata[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rvalid_q[i] <= grant[i] & ~we[i];
                if (grant[i] && !we[i]) rdata_q[i] <= i_ram_rdata;
            end
        end
    end

    assign bus.o_req0_ready  = grant[REQ_CPU];
    assign bus.o_req1_ready  = grant[REQ_DBG];
    assign bus.o_req0_rvalid = rvalid_q[REQ_CPU];
    assign bus.o_req1_rvalid = rvalid_q[REQ_DBG];
    assign bus.o_req0_rdata  = rdata_q[REQ_CPU];
    assign bus.o_req1_rdata  = rdata_q[REQ_DBG];
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic, all
// checked against a rule-level reference model of grants, lock and memory.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int ML = 4;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          o_ram_we;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_wdata, i_ram_rdata;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .bus         (bus),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        logic [11:0] a;
        a = 12'(i);
        return {4'hA, a, 4'h5, a};
    endfunction

    // RAM seen by the DUT (async read, write on rising edge)
    logic [DW-1:0] ram [0:4095];
    assign i_ram_rdata = ram[o_ram_addr];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = init_word(i);
        forever begin
            @(posedge i_clk);
            if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
        end
    end

    // Reference model
    logic [DW-1:0] ref_mem [0:4095];
    int            m_last, m_cnt;
    bit            m_locked;
    bit            m_rv [2];
    logic [DW-1:0] m_rd [2];
    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_locked = 0; m_cnt = 0;
        m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    endtask

    function automatic int model_grant(input bit v0, input bit v1);
        if (!v0 && !v1) return -1;
        if (v0 && !v1)  return (m_locked && m_cnt < ML) ? -1 : 0;
        if (!v0)        return 1;
        if (!m_locked)  return 1 - m_last;
        return (m_cnt < ML) ? 1 : 0;
    endfunction

    // Called just after a falling edge; drives, checks, advances model, returns at next falling edge.
    task automatic cycle(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit lk, output int obs);
        int g;
        bit gwe;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        bus.i_req0_valid = v0; bus.i_req0_we = we0; bus.i_req0_addr = a0; bus.i_req0_wdata = d0;
        bus.i_req1_valid = v1; bus.i_req1_we = we1; bus.i_req1_addr = a1; bus.i_req1_wdata = d1;
        bus.i_req1_lock = lk;
        #1;
        g   = model_grant(v0, v1);
        gwe = (g == 0) ? we0 : (g == 1) ? we1 : 1'b0;
        ga  = (g == 0) ? a0  : (g == 1) ? a1  : '0;
        gd  = (g == 0) ? d0  : (g == 1) ? d1  : '0;
        chk("ready0", 32'(bus.o_req0_ready), 32'(g == 0));
        chk("ready1", 32'(bus.o_req1_ready), 32'(g == 1));
        chk("ram_we", 32'(o_ram_we), 32'(gwe));
        chk("ram_addr", 32'(o_ram_addr), 32'(ga));
        chk("ram_wdata", o_ram_wdata, gd);
        chk("rvalid0", 32'(bus.o_req0_rvalid), 32'(m_rv[0]));
        chk("rvalid1", 32'(bus.o_req1_rvalid), 32'(m_rv[1]));
        chk("rdata0", bus.o_req0_rdata, m_rd[0]);
        chk("rdata1", bus.o_req1_rdata, m_rd[1]);
        obs = bus.o_req1_ready ? 1 : bus.o_req0_ready ? 0 : -1;
        // advance model across the rising edge
        m_rv[0] = 0; m_rv[1] = 0;
        if (g >= 0) begin
            m_last = g;
            if (gwe) ref_mem[ga] = gd;
            else begin m_rd[g] = ref_mem[ga]; m_rv[g] = 1; end
        end
        if (m_locked && m_cnt == ML) begin
            m_locked = 0; m_cnt = 0;
        end else if (g == 1) begin
            if (lk) begin
                m_locked = 1;
                if (v0 && m_cnt < ML) m_cnt++;
            end else begin
                m_locked = 0; m_cnt = 0;
            end
        end else if (!v1) begin
            m_locked = 0; m_cnt = 0;
        end
        @(negedge i_clk);
    endtask

    initial begin
        int obs, k;
        bit p0, p1, rw0, rw1, lk;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] rd0, rd1;
        int pp_exp [6]    = '{0, 1, 0, 1, 0, 1};
        int lock_exp [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};

        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        model_reset();

        // Reset held with both requesters valid
        bus.i_req0_valid = 1'b1; bus.i_req0_we = 1'b0; bus.i_req0_addr = 12'h010; bus.i_req0_wdata = '0;
        bus.i_req1_valid = 1'b1; bus.i_req1_we = 1'b1; bus.i_req1_addr = 12'h020; bus.i_req1_wdata = 32'h1234;
        bus.i_req1_lock = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_ready0", 32'(bus.o_req0_ready), 32'd0);
        chk("rst_ready1", 32'(bus.o_req1_ready), 32'd0);
        chk("rst_ram_we", 32'(o_ram_we), 32'd0);
        chk("rst_rvalid0", 32'(bus.o_req0_rvalid), 32'd0);
        chk("rst_rvalid1", 32'(bus.o_req1_rvalid), 32'd0);
        chk("rst_rdata0", bus.o_req0_rdata, 32'd0);
        chk("rst_rdata1", bus.o_req1_rdata, 32'd0);
        i_rst_n = 1'b1;

        // Ping-pong reads; requester 0 wins the first tie
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b0, 12'h020, '0, 1'b0, obs);
            chk($sformatf("pingpong%0d", i), 32'(obs), 32'(pp_exp[i]));
        end

        // Write then read-back from requester 1
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h0FF, 32'hDEADBEEF, 1'b0, obs);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h0FF, '0, 1'b0, obs);
        #1;
        chk("wr_rd_rvalid1", 32'(bus.o_req1_rvalid), 32'd1);
        chk("wr_rd_rdata1", bus.o_req1_rdata, 32'hDEADBEEF);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, obs);

        // Lock limit: CPU served once after MAX_LOCK debug grants
        cycle(1'b1, 1'b0, 12'h030, '0, 1'b0, 1'b0, '0, '0, 1'b0, obs);
        k = 0; p0 = 1'b1;
        for (int c = 0; c < 11; c++) begin
            cycle(p0, 1'b0, 12'h031, '0, k < 10, 1'b0, 12'(12'h040 + k), '0, k < 9, obs);
            chk($sformatf("lock_seq%0d", c), 32'(obs), 32'(lock_exp[c]));
            if (obs == 1) k++;
            if (obs == 0) p0 = 1'b0;
        end

        // Idle: bus quiet, read data held
        repeat (5) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, obs);
        #1;
        chk("idle_rdata1", bus.o_req1_rdata, init_word(12'h049));
        chk("idle_rdata0", bus.o_req0_rdata, init_word(12'h031));

        // Reset during the third locked grant
        cycle(1'b1, 1'b0, 12'h050, '0, 1'b0, 1'b0, '0, '0, 1'b0, obs);
        cycle(1'b1, 1'b0, 12'h051, '0, 1'b1, 1'b0, 12'h060, '0, 1'b1, obs);
        cycle(1'b1, 1'b0, 12'h051, '0, 1'b1, 1'b0, 12'h061, '0, 1'b1, obs);
        bus.i_req1_addr = 12'h062;
        #1;
        chk("midlock_grant1", 32'(bus.o_req1_ready), 32'd1);
        #1;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("midlock_rst_ready1", 32'(bus.o_req1_ready), 32'd0);
        chk("midlock_rst_ready0", 32'(bus.o_req0_ready), 32'd0);
        chk("midlock_rst_we", 32'(o_ram_we), 32'd0);
        @(posedge i_clk);
        #2;
        chk("midlock_rvalid1", 32'(bus.o_req1_rvalid), 32'd0);
        chk("midlock_rvalid0", 32'(bus.o_req0_rvalid), 32'd0);
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        cycle(1'b1, 1'b0, 12'h051, '0, 1'b1, 1'b0, 12'h062, '0, 1'b1, obs);
        chk("post_reset_grant", 32'(obs), 32'd0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h062, '0, 1'b0, obs);

        // Random traffic with held requests
        p0 = 1'b0; p1 = 1'b0;
        rw0 = 1'b0; rw1 = 1'b0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && $urandom_range(3, 0) != 0) begin
                p0 = 1'b1; rw0 = 1'($urandom_range(1, 0));
                ra0 = 12'($urandom_range(15, 0)); rd0 = $urandom;
            end
            if (!p1 && $urandom_range(3, 0) != 0) begin
                p1 = 1'b1; rw1 = 1'($urandom_range(1, 0));
                ra1 = 12'($urandom_range(15, 0)); rd1 = $urandom;
            end
            lk = ($urandom_range(3, 0) != 0);
            cycle(p0, rw0, ra0, rd0, p1, rw1, ra1, rd1, lk, obs);
            if (obs == 0) p0 = 1'b0;
            if (obs == 1) p1 = 1'b0;
        end
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, obs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares one single-port, asynchronous-read data RAM between the CPU memory stage (requester 0) and the debug unit (requester 1). It drives the RAM write enable, address and write data from the granted requester. It returns registered read data to that requester one cycle after the request is accepted. Fairness is round-robin, with a bounded lock that lets the debug unit hold the port for short bursts when loading or dumping memory.

## Interface
- ADDR_WIDTH, 12: RAM address width (4K words).
- DATA_WIDTH, 32: RAM data width.
- MAX_LOCK, 8: maximum consecutive locked grants to requester 1 while requester 0 is waiting; range 1..255.
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req0_valid / i_req1_valid  in  1  requester N presents a transaction.
- i_req0_we / i_req1_we  in  1  1 = write, 0 = read.
- i_req0_addr / i_req1_addr  in  ADDR_WIDTH  word address.
- i_req0_wdata / i_req1_wdata  in  DATA_WIDTH  write data.
- i_req1_lock  in  1  requester 1 asks to keep the grant on the following cycles.
- o_req0_ready / o_req1_ready  out  1  grant; the transaction is accepted on a clock edge where valid && ready.
- o_req0_rvalid / o_req1_rvalid  out  1  one-cycle pulse: read data for the accepted read is valid.
- o_req0_rdata / o_req1_rdata  out  DATA_WIDTH  registered read data.
- o_ram_we  out  1  RAM write enable; equals valid && ready && we of the granted requester.
- o_ram_addr  out  ADDR_WIDTH  RAM address; the granted requester's address, or 0 when there is no grant.
- o_ram_wdata  out  DATA_WIDTH  RAM write data; the granted requester's wdata, or 0 when there is no grant.
- i_ram_rdata  in  DATA_WIDTH  asynchronous RAM read data for o_ram_addr.

## Operation
- Registered state:
  - last_grant (1 bit): which requester was granted most recently.
  - lock_cnt (8 bits): consecutive locked grants to requester 1 while requester 0 is waiting.
  - locked (1 bit): requester 1 currently holds the lock.
  - rvalid and rdata registers, one set per requester.
- Grant decision is combinational from the valid inputs and registered state. At most one ready is high per cycle.
  - Only one requester valid: that requester is granted, unless it is requester 0 and locked=1 with lock_cnt<MAX_LOCK.
  - Both valid, locked=0: the requester not equal to last_grant wins.
  - Both valid, locked=1: requester 1 wins while lock_cnt<MAX_LOCK. When lock_cnt==MAX_LOCK, requester 0 wins and locked clears.
  - Neither valid: both ready are 0, o_ram_we is 0, address and write data are 0.
- On every accepted transaction:
  - last_grant takes the granted ID.
  - A read loads i_ram_rdata into that requester's rdata register and pulses its rvalid for one cycle.
  - A write only asserts o_ram_we in the accept cycle; rvalid stays 0.
- Lock behaviour:
  - locked sets on an accepted requester-1 transaction with i_req1_lock=1.
  - locked clears when requester 1 is accepted with i_req1_lock=0, when i_req1_valid is 0, or when MAX_LOCK is reached.
  - lock_cnt increments on each locked requester-1 grant while i_req0_valid=1, saturating at MAX_LOCK. It resets to 0 whenever locked clears.
- rdata holds its last value until the next read accepted for the same requester.
- States of the lock FSM: UNLOCKED, LOCKED, FORCED. FORCED is the single cycle in which requester 0 is served after MAX_LOCK, and it returns to UNLOCKED.

## Timing
- Grant latency is 0 cycles: ready is combinational in the same cycle as valid.
- Read latency is 1 cycle: rvalid and rdata are valid in the cycle after acceptance.
- Back-to-back reads from one requester sustain one per cycle.
- Write at address A in cycle n, then read at A in cycle n+1: the read returns the newly written data.
- Reset (asynchronous, any time, including mid-burst or mid-lock):
  - Registers: last_grant=1 (so requester 0 wins the first tie), lock_cnt=0, locked=0, FSM=UNLOCKED, both rvalid=0, both rdata=0.
  - Combinational outputs are forced low during reset: o_reqN_ready=0, o_ram_we=0.
- Requesters must hold valid, we, addr and wdata stable until accepted. The arbiter does not buffer requests.

## Structure
- Shared package ram_arb_pkg holds:
  - localparams REQ_CPU=0 and REQ_DBG=1.
  - Lock FSM state encoding: UNLOCKED, LOCKED, FORCED.
  - Default width constants.
- One natural sub-module, ram_arb_grant: combinational grant logic plus the lock FSM and lock_cnt.
- The top level contains the RAM mux and the response registers. The RAM itself stays outside this block.

## Test plan
- Reset: hold i_rst_n=0 with both valid=1 -> both ready=0, o_ram_we=0, rvalid=0, rdata=0. On release, requester 0 is granted first.
- Ping-pong: both requesters issue continuous reads to 0x010 and 0x020 -> grants alternate 0,1,0,1 and each rvalid arrives one cycle after its accept, carrying that address's RAM data.
- Write then read: requester 1 writes 0xDEADBEEF to 0x0FF, then reads 0x0FF the next cycle -> o_req1_rdata=0xDEADBEEF with o_req1_rvalid=1 one cycle after the read is accepted.
- Lock limit: MAX_LOCK=4, requester 1 locked burst of 10 with requester 0 waiting -> 4 grants to requester 1, then 1 grant to requester 0, then requester 1 resumes.
- Mid-lock reset: assert i_rst_n=0 during the third locked grant -> locked=0, lock_cnt=0, no rvalid pulse is produced for the aborted cycle.
- Idle: both valid=0 for 5 cycles -> o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, rdata registers unchanged.
